// File: rtl/mul_datapath_if.sv
// Operand/control/result bundle for the shift-free repeated-addition multiplier.
// The controller drives the master side; mul_datapath sits on the slave side.
interface mul_datapath_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             ldA;
  logic             ldB;
  logic             ldP;
  logic             clrP;
  logic             decB;
  logic             eqz;
  logic [WIDTH-1:0] product;
  logic             ovf;

  modport master (
    output data_in, ldA, ldB, ldP, clrP, decB,
    input  eqz, product, ovf
  );

  modport slave (
    input  data_in, ldA, ldB, ldP, clrP, decB,
    output eqz, product, ovf
  );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand A, down-counter B, accumulator P.
// Define MUL_DATAPATH_OVF_EN to build the sticky accumulate-overflow flag; otherwise ovf is tied low.
module mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  mul_datapath_if.slave bus
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             b_zero;
  logic             acc_en;

  assign b_zero = (b_q == '0);
  // Accumulation is gated by B so surplus ldP cycles leave the result untouched.
  assign acc_en = bus.ldP && !b_zero;

  always_comb begin
    a_d = a_q;
    if (bus.ldA) a_d = bus.data_in;
  end

  always_comb begin
    b_d = b_q;
    if (bus.ldB)                b_d = bus.data_in;
    else if (bus.decB && !b_zero) b_d = b_q - 1'b1;
  end

`ifdef MUL_DATAPATH_OVF_EN
  logic [WIDTH:0] sum;
  logic           ovf_q, ovf_d;

  assign sum = {1'b0, p_q} + {1'b0, a_q};

  always_comb begin
    p_d   = p_q;
    ovf_d = ovf_q;
    if (bus.clrP) begin
      p_d   = '0;
      ovf_d = 1'b0;
    end else if (acc_en) begin
      p_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  always_comb begin
    p_d = p_q;
    if (bus.clrP)    p_d = '0;
    else if (acc_en) p_d = p_q + a_q;
  end

  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign bus.eqz     = b_zero;
  assign bus.product = p_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Directed-vector bench for mul_datapath; ovf expectations follow MUL_DATAPATH_OVF_EN.
module tb_mul_datapath;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef MUL_DATAPATH_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  mul_datapath_if #(.WIDTH(WIDTH)) bus ();

  mul_datapath #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [WIDTH-1:0] d, input logic la, input logic lb,
                     input logic lp, input logic cp, input logic db);
    bus.data_in = d;
    bus.ldA = la; bus.ldB = lb; bus.ldP = lp; bus.clrP = cp; bus.decB = db;
  endtask

  task automatic idle();
    ctl('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_state(input string name, input logic [WIDTH-1:0] p,
                              input logic z, input logic o);
    checks++;
    if (bus.product !== p || bus.eqz !== z || bus.ovf !== o) begin
      errors++;
      $display("FAIL %s: got product=%h eqz=%b ovf=%b, want product=%h eqz=%b ovf=%b",
               name, bus.product, bus.eqz, bus.ovf, p, z, o);
    end else begin
      $display("ok   %s: product=%h eqz=%b ovf=%b", name, bus.product, bus.eqz, bus.ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctl(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    expect_state("reset", 16'h0, 1'b1, 1'b0);
    rst = 1'b0;
    ctl(16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_state("reset_ldB2", 16'h0, 1'b0, 1'b0);
    // A was cleared by reset, so accumulating must leave P at zero.
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    expect_state("reset_A_zero", 16'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_multiply();
    ctl(16'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    ctl(16'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    ctl('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);    tick();
    expect_state("mul_setup", 16'h0, 1'b0, 1'b0);
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      expect_state($sformatf("mul7x5_cyc%0d", i), 16'(7 * ((i < 5) ? i : 5)),
                   (i >= 5), 1'b0);
    end
    idle();
  endtask

  task automatic test_zero_b();
    ctl(16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    expect_state("zb_load", 16'h0, 1'b1, 1'b0);
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    expect_state("zb_hold", 16'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_priority();
    ctl(16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    expect_state("ldB_over_decB", 16'h0, 1'b0, 1'b0);
    ctl('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    expect_state("decB_2of3", 16'h0, 1'b0, 1'b0);
    tick();
    expect_state("decB_3of3", 16'h0, 1'b1, 1'b0);
    // Shared load: A and B both take 2.
    ctl(16'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("shared_ld_acc1", 16'd2, 1'b0, 1'b0);
    tick();
    expect_state("shared_ld_acc2", 16'd4, 1'b0, 1'b0);
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_state("clrP_over_ldP", 16'h0, 1'b0, 1'b0);
    idle(); tick();
    expect_state("idle_hold", 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_ovf();
    ctl(16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    ctl(16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);    tick();
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    expect_state("ovf_acc1", 16'h8000, 1'b0, 1'b0);
    tick();
    expect_state("ovf_acc2", 16'h0000, 1'b0, OVF_ON);
    tick();
    expect_state("ovf_acc3", 16'h8000, 1'b1, OVF_ON);
    idle(); tick();
    expect_state("ovf_sticky", 16'h8000, 1'b1, OVF_ON);
    ctl('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    expect_state("ovf_clrP", 16'h0, 1'b1, 1'b0);
    // clrP coinciding with an accumulate that would carry out.
    ctl(16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);    tick();
    expect_state("ovf_pre", 16'h8000, 1'b0, 1'b0);
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);    tick();
    expect_state("ovf_clr_wins", 16'h0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic test_reset_mid();
    ctl(16'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    ctl(16'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    expect_state("mid_acc2", 16'd18, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    expect_state("mid_reset", 16'h0, 1'b1, 1'b0);
    rst = 1'b0;
    ctl(16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    ctl(16'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    ctl('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    expect_state("fresh_acc3", 16'd9, 1'b0, 1'b0);
    tick();
    expect_state("fresh_3x4", 16'd12, 1'b1, 1'b0);
    tick();
    expect_state("fresh_extra", 16'd12, 1'b1, 1'b0);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_multiply();
    test_zero_b();
    test_priority();
    test_ovf();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
